// File: rtl/lix_cbuf_if.sv
// Stream-side bundle for lix_cbuf: pipeline inject handshake, pipeline result
// input and the downstream valid/ready output.
interface lix_cbuf_if #(
  parameter int unsigned W = 32
);
  logic         i_vld;
  logic         o_rdy;
  logic         o_pvld;
  logic [W-1:0] i_x;
  logic         o_vld;
  logic [W-1:0] o_z;
  logic         i_rdy;

  modport slave (
    input  i_vld,
    input  i_x,
    input  i_rdy,
    output o_rdy,
    output o_pvld,
    output o_vld,
    output o_z
  );

  modport master (
    output i_vld,
    output i_x,
    output i_rdy,
    input  o_rdy,
    input  o_pvld,
    input  o_vld,
    input  o_z
  );
endinterface

// File: rtl/lix_cbuf.sv
// Credit-based output buffer: turns a fixed-latency, always-enabled pipeline
// into a valid/ready stream without losing results under back-pressure.
module lix_cbuf #(
  parameter int unsigned W = 32,
  parameter int unsigned N = 2,
  parameter int unsigned D = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  lix_cbuf_if.slave  bus
);

  localparam int unsigned CW = $clog2(D + 1);
  localparam int unsigned PW = (D > 1) ? $clog2(D) : 1;
  localparam logic [CW-1:0] CNT_MAX  = CW'(D);
  localparam logic [PW-1:0] PTR_LAST = PW'(D - 1);

  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] occ, occ_nxt;
  logic [PW-1:0] wp, wp_nxt;
  logic [PW-1:0] rp, rp_nxt;
  logic [N-1:0]  vl, vl_nxt;
  logic [W-1:0]  mem [D];

  logic rdy_c;
  logic vld_c;
  logic acc_c;
  logic pop_c;
  logic push_c;

  // Handshake decode; o_rdy depends only on registers and reset.
  assign rdy_c  = rst_ni & (cnt != CNT_MAX);
  assign acc_c  = bus.i_vld & rdy_c;
  assign vld_c  = (occ != '0);
  assign pop_c  = vld_c & bus.i_rdy;
  assign push_c = vl[N-1];

  assign bus.o_rdy  = rdy_c;
  assign bus.o_pvld = acc_c;
  assign bus.o_vld  = vld_c;
  assign bus.o_z    = mem[rp];

  // Credits cover tokens in flight plus FIFO occupancy.
  always_comb begin
    cnt_nxt = cnt;
    if (acc_c && !pop_c) begin
      cnt_nxt = cnt + CW'(1);
    end else if (!acc_c && pop_c) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  always_comb begin
    occ_nxt = occ;
    if (push_c && !pop_c) begin
      occ_nxt = occ + CW'(1);
    end else if (!push_c && pop_c) begin
      occ_nxt = occ - CW'(1);
    end
  end

  // Pointers wrap explicitly so D need not be a power of two.
  always_comb begin
    wp_nxt = wp;
    rp_nxt = rp;
    if (push_c) begin
      wp_nxt = (wp == PTR_LAST) ? '0 : wp + PW'(1);
    end
    if (pop_c) begin
      rp_nxt = (rp == PTR_LAST) ? '0 : rp + PW'(1);
    end
  end

  // Valid shadow of the pipeline: bit N-1 marks the cycle i_x is meaningful.
  always_comb begin
    vl_nxt = (vl << 1) | N'(acc_c);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt <= '0;
      occ <= '0;
      wp  <= '0;
      rp  <= '0;
      vl  <= '0;
    end else begin
      cnt <= cnt_nxt;
      occ <= occ_nxt;
      wp  <= wp_nxt;
      rp  <= rp_nxt;
      vl  <= vl_nxt;
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (rst_ni && push_c) begin
      mem[wp] <= bus.i_x;
    end
  end

  always @(posedge clk_i) begin
    if (rst_ni) begin
      assert (!(push_c && occ == CNT_MAX))
        else $error("lix_cbuf: push while full");
      assert (!(pop_c && occ == '0))
        else $error("lix_cbuf: pop while empty");
    end
  end

endmodule

// File: doc/lix_cbuf.md
# lix_cbuf

Credit-based output buffer for the fixed-latency masked-arithmetic pipelines in the A2B datapath. It converts an enable-only, free-running pipeline built from `lix_shr0`-style register chains into a valid/ready stream. Upstream, it gates how many tokens may enter the pipeline. Downstream, it captures each result N cycles after entry into a D-entry FIFO and presents it with valid/ready, so results are never lost under back-pressure.

## Interface
- `W`, default 32, data width.
- `N`, default 2, latency of the attached pipeline in cycles (≥1); the pipeline's `i_en` is tied high.
- `D`, default 4, FIFO depth and credit count (≥1); 100% throughput requires D ≥ N+2.
- `clk_i`  in  1  single clock, rising edge.
- `rst_ni`  in  1  reset, synchronous, active-low.
- `i_vld`  in  1  upstream request to inject a token into the pipeline.
- `o_rdy`  out  1  credit available; a token is accepted when `i_vld & o_rdy`.
- `o_pvld`  out  1  `i_vld & o_rdy`; drives the pipeline's input valid.
- `i_x`  in  W  pipeline output data; sampled exactly N cycles after acceptance.
- `o_vld`  out  1  FIFO non-empty.
- `o_z`  out  W  FIFO head data.
- `i_rdy`  in  1  downstream ready; a pop occurs when `o_vld & i_rdy`.

## Operation
- Credit counter `cnt`, width clog2(D+1), range 0..D.
  - `cnt` = tokens in flight plus FIFO occupancy.
  - `cnt_next = cnt + acc − pop`, where `acc = i_vld & o_rdy` and `pop = o_vld & i_rdy`.
  - Simultaneous `acc` and `pop` leave `cnt` unchanged.
- `o_rdy = rst_ni & (cnt != D)`. It is a function of registers and `rst_ni` only; there is no combinational path from `i_rdy` or `i_vld`.
- Valid delay line `vl[N-1:0]`:
  - `vl[0] <= acc` and `vl[k] <= vl[k-1]`, shifting every cycle.
  - `vl[N-1]` marks the cycle in which `i_x` carries an accepted token's result.
- FIFO:
  - D×W storage; read and write pointers wrap from D−1 to 0, and D need not be a power of two.
  - An occupancy register is kept separately from `cnt`.
  - Push when `vl[N-1]`, writing `i_x`. Pop as defined above.
  - Simultaneous push and pop are legal, including when the FIFO is empty-plus-push (no bypass: data becomes visible the next cycle) or full-minus-pop.
- Overflow is structurally impossible because credits bound occupancy plus in-flight tokens to D.
  - Simulation assertions fire on push while full and on pop while empty.
- Ordering: strict FIFO order. Results leave in acceptance order.
- Reset (`rst_ni` low at a clock edge):
  - `cnt`, pointers, occupancy and `vl` are cleared to 0.
  - In-flight tokens are discarded; stale pipeline data arriving afterwards is never pushed.
  - FIFO storage is not reset.

## Timing
- Reset values:
  - `o_rdy` = 0 while `rst_ni` = 0, and 1 in the first cycle after release.
  - `o_vld` = 0, `o_pvld` = 0.
  - `o_z` is don't-care while `o_vld` = 0.
- Latency: a token accepted in cycle t is sampled on `i_x` in cycle t+N and appears on `o_vld`/`o_z` in cycle t+N+1 (minimum).
- Credit round trip:
  - A credit taken in cycle t is returned by a pop no earlier than cycle t+N+1.
  - It is usable by `o_rdy` in cycle t+N+2.
  - This is why D ≥ N+2 is needed for one token per cycle sustained.
- `o_z` is held stable while `o_vld & ~i_rdy`.
- Throughput: one accept and one pop per cycle maximum.

## Test plan
- **Reset:** hold `rst_ni`=0 for 3 cycles with `i_vld`=1 and `i_rdy`=1.
  - Required: `o_rdy`, `o_pvld` and `o_vld` are all 0 throughout.
  - Required: `o_rdy`=1 in the first cycle after release.
- **Single token** (N=2, D=4): accept in cycle t; the model drives `i_x`=0xA5A50001 in cycle t+2.
  - Required: `o_vld`=1 and `o_z`=0xA5A50001 in cycle t+3.
  - Required: with `i_rdy`=1, `o_vld`=0 in cycle t+4.
- **Streaming:** `i_vld`=1 and `i_rdy`=1 for 100 cycles, pipeline model echoing an incrementing count.
  - Required: `o_rdy` never drops.
  - Required: 100 outputs 0..99 in order, one per cycle from cycle N+1.
- **Back-pressure:** `i_rdy`=0 with `i_vld`=1.
  - Required: exactly 4 accepts, then `o_rdy`=0 with `cnt`=4.
  - Then raise `i_rdy`. Required: 4 outputs in order, and `o_rdy` returns to 1 the cycle after the first pop.
- **Boundary:** with `cnt`=3 (one FIFO entry, two in flight), drive an accept and a pop in the same cycle.
  - Required: `cnt` stays 3 and `o_rdy` stays 1.
  - Required: with `i_rdy` held 0 next cycle, `o_rdy` falls when `cnt` reaches 4.
- **Mid-stream reset:** assert `rst_ni`=0 for 1 cycle with 2 tokens in flight and 2 in the FIFO.
  - Required: `o_vld`=0 afterwards, even though the model still presents data on `i_x` for the old tokens.
  - Required: the next accepted token is the first output.
